noc_vc_credit_controller: RTL and testbench

Per-output-port credit and packet-state controller for the router's virtual channels. It tracks downstream buffer credits per VC and the open/closed state of the packet on each VC. From these it drives the `vc_ready` vector consumed by the port-control arbitration stage, so a VC is only granted when the downstream buffer can accept the flit. It sits between the port controller's output and the link to the neighbouring router.

---
 rtl/noc_vc_credit_controller_pkg.sv | 12 +
 rtl/noc_vc_credit_counter.sv | 77 +++++++
 rtl/noc_vc_credit_controller.sv | 73 +++++++
 tb/tb_noc_vc_credit_controller.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_vc_credit_controller_pkg.sv
// Shared NoC router parameters, plus the per-VC packet state used by the credit controller.
package Noc_parameters;

    localparam int Noc_VC_Channel = 4;
    localparam int Noc_VC_Credits = 4;

    typedef enum logic {
        VC_IDLE   = 1'b0,
        VC_ACTIVE = 1'b1
    } noc_vc_state_e;

endpackage

// File: rtl/noc_vc_credit_counter.sv
// One VC: the downstream credit counter, the packet-open FSM and the grant-readiness decode.
// With NOC_CREDIT_ERROR_CHECK_EN defined it also flags per-VC credit/protocol violations.
module noc_vc_credit_counter
    import Noc_parameters::*;
#(
    parameter int   CREDITS   = Noc_VC_Credits,
    parameter int   MIN_START = 1,
    localparam int  CW        = $clog2(CREDITS + 1)
) (
    input  logic          noc_clk,
    input  logic          noc_rst_n,
    input  logic          i_send,
    input  logic          i_sop,
    input  logic          i_eop,
    input  logic          i_credit_return,
    output logic [CW-1:0] o_count,
    output logic          o_ready,
    output logic          o_busy
`ifdef NOC_CREDIT_ERROR_CHECK_EN
    ,
    output logic          o_error
`endif
);

    localparam logic [CW-1:0] MAX_CREDITS = CW'(CREDITS);
    localparam logic [CW-1:0] START_LEVEL = CW'(MIN_START);

    logic [CW-1:0]  r_count;
    noc_vc_state_e  r_state;
    logic           w_dec;
    logic           w_inc;

    // A send and a return in the same cycle cancel, which keeps streaming VCs steady.
    assign w_dec = i_send & ~i_credit_return;
    assign w_inc = i_credit_return & ~i_send;

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            r_count <= MAX_CREDITS;
            r_state <= VC_IDLE;
        end else begin
            if (w_dec && (r_count != '0)) begin
                r_count <= r_count - CW'(1);
            end else if (w_inc && (r_count != MAX_CREDITS)) begin
                r_count <= r_count + CW'(1);
            end

            // A single-flit packet (sop and eop together) never opens the VC.
            if (i_send) begin
                if ((r_state == VC_IDLE) && i_sop && !i_eop) begin
                    r_state <= VC_ACTIVE;
                end else if ((r_state == VC_ACTIVE) && i_eop) begin
                    r_state <= VC_IDLE;
                end
            end
        end
    end

    assign o_count = r_count;
    assign o_busy  = (r_state == VC_ACTIVE);
    // Decoded from registers only, so arbitration sees no input-to-ready path.
    assign o_ready = o_busy ? (r_count != '0) : (r_count >= START_LEVEL);

`ifdef NOC_CREDIT_ERROR_CHECK_EN
    logic w_underflow;
    logic w_overflow;
    logic w_sop_on_active;
    logic w_body_on_idle;

    assign w_underflow     = w_dec && (r_count == '0);
    assign w_overflow      = w_inc && (r_count == MAX_CREDITS);
    assign w_sop_on_active = i_send && i_sop && (r_state == VC_ACTIVE);
    assign w_body_on_idle  = i_send && !i_sop && (r_state == VC_IDLE);
    assign o_error         = w_underflow | w_overflow | w_sop_on_active | w_body_on_idle;
`endif

endmodule

// File: rtl/noc_vc_credit_controller.sv
// Per-output-port VC credit and packet-state controller driving vc_ready to the arbiter.
// Optional sticky error checking is built when NOC_CREDIT_ERROR_CHECK_EN is defined.
module noc_vc_credit_controller
    import Noc_parameters::*;
#(
    parameter int  CHANNELS  = Noc_VC_Channel,
    parameter int  CREDITS   = Noc_VC_Credits,
    parameter int  MIN_START = 1,
    localparam int CW        = $clog2(CREDITS + 1)
) (
    input  logic                         noc_clk,
    input  logic                         noc_rst_n,
    input  logic                         flit_valid,
    input  logic [CHANNELS-1:0]          flit_vc,
    input  logic                         flit_sop,
    input  logic                         flit_eop,
    input  logic [CHANNELS-1:0]          credit_return,
    output logic [CHANNELS-1:0]          vc_ready,
    output logic [CHANNELS-1:0]          vc_busy,
    output logic [CHANNELS-1:0][CW-1:0]  credit_count,
    output logic                         error
);

    logic [CHANNELS-1:0] w_send;

    assign w_send = {CHANNELS{flit_valid}} & flit_vc;

`ifdef NOC_CREDIT_ERROR_CHECK_EN
    logic [CHANNELS-1:0] w_vc_err;
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_vc
        noc_vc_credit_counter #(
            .CREDITS   (CREDITS),
            .MIN_START (MIN_START)
        ) u_counter (
            .noc_clk         (noc_clk),
            .noc_rst_n       (noc_rst_n),
            .i_send          (w_send[g]),
            .i_sop           (flit_sop),
            .i_eop           (flit_eop),
            .i_credit_return (credit_return[g]),
            .o_count         (credit_count[g]),
            .o_ready         (vc_ready[g]),
            .o_busy          (vc_busy[g])
`ifdef NOC_CREDIT_ERROR_CHECK_EN
            ,
            .o_error         (w_vc_err[g])
`endif
        );
    end

`ifdef NOC_CREDIT_ERROR_CHECK_EN
    logic w_vc_select_err;
    logic r_error;

    // A valid flit must name exactly one VC; anything else is a protocol error.
    assign w_vc_select_err = flit_valid && !$onehot(flit_vc);

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            r_error <= 1'b0;
        end else if ((|w_vc_err) || w_vc_select_err) begin
            r_error <= 1'b1;
        end
    end

    assign error = r_error;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_noc_vc_credit_controller.sv
// Randomized and directed bench for noc_vc_credit_controller (2 VCs, 4 credits).
module tb_noc_vc_credit_controller;

    localparam int CH = 2;
    localparam int CR = 4;
    localparam int CW = 3;
`ifdef NOC_CREDIT_ERROR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                  noc_clk = 1'b0;
    logic                  noc_rst_n;
    logic                  flit_valid;
    logic [CH-1:0]         flit_vc;
    logic                  flit_sop;
    logic                  flit_eop;
    logic [CH-1:0]         credit_return;
    logic [CH-1:0]         rdy_a, busy_a, rdy_b, busy_b;
    logic [CH-1:0][CW-1:0] cnt_a, cnt_b;
    logic                  err_a, err_b;

    int n_checks = 0;
    int n_pass   = 0;

    int m_cnt [CH];
    bit m_open[CH];
    bit m_err;

    always #5 noc_clk = ~noc_clk;

    noc_vc_credit_controller #(.CHANNELS(CH), .CREDITS(CR), .MIN_START(1)) u_dut_a (
        .noc_clk(noc_clk), .noc_rst_n(noc_rst_n), .flit_valid(flit_valid), .flit_vc(flit_vc),
        .flit_sop(flit_sop), .flit_eop(flit_eop), .credit_return(credit_return),
        .vc_ready(rdy_a), .vc_busy(busy_a), .credit_count(cnt_a), .error(err_a)
    );

    noc_vc_credit_controller #(.CHANNELS(CH), .CREDITS(CR), .MIN_START(3)) u_dut_b (
        .noc_clk(noc_clk), .noc_rst_n(noc_rst_n), .flit_valid(flit_valid), .flit_vc(flit_vc),
        .flit_sop(flit_sop), .flit_eop(flit_eop), .credit_return(credit_return),
        .vc_ready(rdy_b), .vc_busy(busy_b), .credit_count(cnt_b), .error(err_b)
    );

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) begin
            m_cnt[i]  = CR;
            m_open[i] = 1'b0;
        end
        m_err = 1'b0;
    endfunction

    function automatic void model_step();
        int ones;
        ones = 0;
        for (int i = 0; i < CH; i++) ones += int'(flit_vc[i]);
        if (ERR_EN && flit_valid && ones != 1) m_err = 1'b1;
        for (int i = 0; i < CH; i++) begin
            bit snd, ret;
            snd = flit_valid && flit_vc[i];
            ret = credit_return[i];
            if (ERR_EN) begin
                if (snd && !ret && m_cnt[i] == 0)  m_err = 1'b1;
                if (ret && !snd && m_cnt[i] == CR) m_err = 1'b1;
                if (snd && flit_sop && m_open[i])   m_err = 1'b1;
                if (snd && !flit_sop && !m_open[i]) m_err = 1'b1;
            end
            if (snd && !ret) m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
            if (ret && !snd) m_cnt[i] = (m_cnt[i] < CR) ? m_cnt[i] + 1 : CR;
            if (snd) begin
                if (!m_open[i] && flit_sop && !flit_eop) m_open[i] = 1'b1;
                else if (m_open[i] && flit_eop)          m_open[i] = 1'b0;
            end
        end
    endfunction

    function automatic logic [21:0] exp_vec();
        logic [5:0] c;
        logic [1:0] ra, rb, b;
        for (int i = 0; i < CH; i++) begin
            c[i*3 +: 3] = 3'(m_cnt[i]);
            ra[i] = m_open[i] ? (m_cnt[i] != 0) : (m_cnt[i] >= 1);
            rb[i] = m_open[i] ? (m_cnt[i] != 0) : (m_cnt[i] >= 3);
            b[i]  = m_open[i];
        end
        return {c, ra, rb, b, m_err, c, b, m_err};
    endfunction

    function automatic logic [21:0] act_vec();
        return {cnt_a, rdy_a, rdy_b, busy_a, err_a, cnt_b, busy_b, err_b};
    endfunction

    task automatic drive(input logic v, input logic [1:0] vc, input logic s, input logic e,
                         input logic [1:0] r);
        flit_valid = v; flit_vc = vc; flit_sop = s; flit_eop = e; credit_return = r;
    endtask

    task automatic cycle();
        @(posedge noc_clk);
        model_step();
        #1;
    endtask

    task automatic test_reset(input string tag);
        drive(0, 2'b00, 0, 0, 2'b00);
        noc_rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (act_vec() !== exp_vec() || cnt_a[0] !== 3'd4 || rdy_a !== 2'b11 || err_a !== 1'b0)
            $display("FAIL reset_%s act=%h exp=%h", tag, act_vec(), exp_vec());
        else n_pass++;
        @(posedge noc_clk);
        #1;
        noc_rst_n = 1'b1;
        cycle();
        n_checks++;
        if (act_vec() !== exp_vec()) $display("FAIL reset_%s_release act=%h exp=%h", tag, act_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_credit_drain();
        for (int k = 0; k < 4; k++) begin
            drive(1, 2'b01, k == 0, k == 3, 2'b00);
            cycle();
            n_checks++;
            if (act_vec() !== exp_vec()) $display("FAIL drain[%0d] act=%h exp=%h", k, act_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (cnt_a[0] !== 3'd0 || rdy_a[0] !== 1'b0 || busy_a[0] !== 1'b0)
            $display("FAIL drain_empty cnt=%0d rdy=%b busy=%b exp cnt=0 rdy=0 busy=0", cnt_a[0], rdy_a[0], busy_a[0]);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            drive(0, 2'b00, 0, 0, 2'b01);
            cycle();
            n_checks++;
            if (act_vec() !== exp_vec()) $display("FAIL refill[%0d] act=%h exp=%h", k, act_vec(), exp_vec());
            else n_pass++;
        end
        drive(0, 2'b00, 0, 0, 2'b00);
    endtask

    task automatic test_streaming();
        for (int k = 0; k < 20; k++) begin
            drive(1, 2'b10, k == 0, k == 19, 2'b10);
            cycle();
            n_checks++;
            if (act_vec() !== exp_vec() || cnt_a[1] !== 3'd4 || rdy_a[1] !== 1'b1)
                $display("FAIL stream[%0d] act=%h exp=%h", k, act_vec(), exp_vec());
            else n_pass++;
        end
        drive(0, 2'b00, 0, 0, 2'b00);
    endtask

    task automatic test_start_threshold();
        for (int k = 0; k < 2; k++) begin
            drive(1, 2'b01, 1, 1, 2'b00);
            cycle();
        end
        drive(0, 2'b00, 0, 0, 2'b00);
        cycle();
        n_checks++;
        if (act_vec() !== exp_vec() || rdy_b[0] !== 1'b0 || rdy_a[0] !== 1'b1)
            $display("FAIL thresh_below act=%h exp=%h", act_vec(), exp_vec());
        else n_pass++;
        drive(0, 2'b00, 0, 0, 2'b01);
        cycle();
        n_checks++;
        if (act_vec() !== exp_vec() || rdy_b[0] !== 1'b1 || cnt_b[0] !== 3'd3)
            $display("FAIL thresh_rearm act=%h exp=%h", act_vec(), exp_vec());
        else n_pass++;
        cycle();
        drive(0, 2'b00, 0, 0, 2'b00);
    endtask

    task automatic test_overflow();
        drive(0, 2'b00, 0, 0, 2'b01);
        cycle();
        n_checks++;
        if (act_vec() !== exp_vec() || cnt_a[0] !== 3'd4 || err_a !== ERR_EN)
            $display("FAIL overflow act=%h exp=%h", act_vec(), exp_vec());
        else n_pass++;
        drive(0, 2'b00, 0, 0, 2'b00);
        repeat (3) cycle();
        n_checks++;
        if (act_vec() !== exp_vec() || err_a !== ERR_EN)
            $display("FAIL overflow_sticky err=%b exp=%b", err_a, ERR_EN);
        else n_pass++;
        test_reset("ovf_clear");
    endtask

    task automatic test_underflow();
        for (int k = 0; k < 5; k++) begin
            drive(1, 2'b01, 1, 1, 2'b00);
            cycle();
            n_checks++;
            if (act_vec() !== exp_vec()) $display("FAIL underflow[%0d] act=%h exp=%h", k, act_vec(), exp_vec());
            else n_pass++;
        end
        test_reset("unf_clear");
    endtask

    task automatic test_protocol();
        for (int k = 0; k < 2; k++) begin
            drive(1, 2'b01, 1, 0, 2'b00);
            cycle();
            n_checks++;
            if (act_vec() !== exp_vec()) $display("FAIL sop_on_active[%0d] act=%h exp=%h", k, act_vec(), exp_vec());
            else n_pass++;
        end
        test_reset("midpkt");
        drive(1, 2'b11, 1, 1, 2'b00);
        cycle();
        n_checks++;
        if (act_vec() !== exp_vec() || err_a !== ERR_EN)
            $display("FAIL vc_not_onehot act=%h exp=%h", act_vec(), exp_vec());
        else n_pass++;
        test_reset("proto_clear");
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            int sel;
            logic [1:0] vc;
            sel = int'($urandom_range(0, 7));
            vc  = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b11 : (sel < 5) ? 2'b01 : 2'b10;
            drive(1'($urandom_range(0, 1)), vc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)));
            cycle();
            n_checks++;
            if (act_vec() !== exp_vec()) $display("FAIL random[%0d] act=%h exp=%h", k, act_vec(), exp_vec());
            else n_pass++;
            if (k % 50 == 49) test_reset("random");
        end
        drive(0, 2'b00, 0, 0, 2'b00);
    endtask

    initial begin
        noc_rst_n = 1'b1;
        drive(0, 2'b00, 0, 0, 2'b00);
        model_reset();
        #2;
        test_reset("initial");
        test_credit_drain();
        test_streaming();
        test_start_threshold();
        test_overflow();
        test_underflow();
        test_protocol();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
